ramn: RTL and testbench

RAMN -- requirements
Module: ramn

---
 rtl/hack_pkg.sv | 17 +
 rtl/regn.sv | 31 +++
 rtl/ramn.sv | 107 ++++++++++
 tb/tb_ramn.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/hack_pkg.sv
// ---------------------------------------------------------------------------
// hack_pkg
//   Shared definitions for the ramn word store: the default geometry
//   constants and the two-state clear-sweep FSM encoding.
// ---------------------------------------------------------------------------
package hack_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_DEPTH = 8;

    // IDLE: normal read/write access. CLEAR: zeroing sweep in progress.
    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

endpackage : hack_pkg

// File: rtl/regn.sv
// ---------------------------------------------------------------------------
// regn
//   One storage word: a WIDTH-bit register that captures 'in' on a rising
//   clock edge when 'load' is high and holds its value otherwise.
//
//   Ports
//     clk   : clock, rising edge active
//     in    : data to capture
//     load  : capture enable
//     out   : stored word
// ---------------------------------------------------------------------------
module regn #(
    parameter int WIDTH = hack_pkg::DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    output logic [WIDTH-1:0] out
);

    // NOTE: storage words carry no reset; the owner clears them with a
    // one-word-per-cycle sweep, which keeps the array a plain register file.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is always assigned with <= so every
        // register samples pre-edge values regardless of statement order.
        if (load) begin
            out <= in;
        end
    end

endmodule : regn

// File: rtl/ramn.sv
// ---------------------------------------------------------------------------
// ramn
//   DEPTH x WIDTH word store built from regn registers, with a zero-cycle
//   read port and a self-clearing sweep. A reset edge starts a sweep that
//   zeroes one word per cycle; while it runs, busy is high, out reads 0
//   and user writes are ignored.
//
//   Ports
//     clk     : clock, rising edge active
//     reset   : synchronous, active-high; (re)starts the clear sweep
//     in      : write data
//     load    : write enable (honoured only when idle and not in reset)
//     address : word select for both read and write
//     out     : read data, mem[address] when idle, 0 while busy
//     busy    : high while the clear sweep is in progress
// ---------------------------------------------------------------------------
module ramn
    import hack_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic [AW-1:0]    address,
    output logic [WIDTH-1:0] out,
    output logic             busy
);

    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    state_t          state, next_state;
    logic [AW-1:0]   ptr, next_ptr;

    logic            sweep_we;
    logic            user_we;
    logic [AW-1:0]   wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic [DEPTH-1:0] word_load;
    logic [WIDTH-1:0] word_q [DEPTH];

    // ---------------- FSM state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CLEAR;
            ptr   <= '0;
        end else begin
            state <= next_state;
            ptr   <= next_ptr;
        end
    end

    // ---------------- FSM next state ----------------
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no
        // latch is inferred.
        next_state = state;
        next_ptr   = ptr;
        unique case (state)
            IDLE: begin
                next_ptr = '0;
            end
            CLEAR: begin
                // Explicit compare against the last index: ptr never wraps
                // while the sweep is still running.
                if (ptr == LAST_PTR) begin
                    next_state = IDLE;
                    next_ptr   = '0;
                end else begin
                    next_ptr = ptr + 1'b1;
                end
            end
            default: begin
                next_state = CLEAR;
                next_ptr   = '0;
            end
        endcase
    end

    assign busy = (state == CLEAR);

    // ---------------- Write decode ----------------
    // Reset suppresses both write sources, so a reset edge touches no word
    // and a simultaneous reset+load drops the user write.
    assign sweep_we = busy && !reset;
    assign user_we  = !busy && !reset && load;
    assign wr_addr  = sweep_we ? ptr : address;
    assign wr_data  = sweep_we ? '0 : in;

    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        assign word_load[i] = (sweep_we || user_we) && (wr_addr == AW'(i));

        regn #(.WIDTH(WIDTH)) u_word (
            .clk  (clk),
            .in   (wr_data),
            .load (word_load[i]),
            .out  (word_q[i])
        );
    end

    // ---------------- Read mux ----------------
    assign out = busy ? '0 : word_q[address];

endmodule : ramn

// File: tb/tb_ramn.sv
// ---------------------------------------------------------------------------
// tb_ramn
//   Self-checking bench for ramn (WIDTH=16, DEPTH=8). A behavioural model
//   tracks the memory as an array plus a count of sweep cycles remaining;
//   each step is checked before and after its clock edge.
// ---------------------------------------------------------------------------
module tb_ramn;

    localparam int WIDTH = 16;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic             clk;
    logic             reset;
    logic             load;
    logic [WIDTH-1:0] in_d;
    logic [AW-1:0]    address;
    logic [WIDTH-1:0] out_d;
    logic             busy;

    ramn #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .in      (in_d),
        .load    (load),
        .address (address),
        .out     (out_d),
        .busy    (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    logic [WIDTH-1:0] model_mem [DEPTH];
    int               sweep_left;
    int               n_checks;
    int               n_pass;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    endtask

    // Apply one clock edge to the model using the inputs currently driven.
    task automatic model_edge();
        if (reset) begin
            sweep_left = DEPTH;
        end else if (sweep_left > 0) begin
            sweep_left--;
            if (sweep_left == 0) begin
                foreach (model_mem[i]) model_mem[i] = '0;
            end
        end else if (load) begin
            model_mem[address] = in_d;
        end
    endtask

    function automatic logic [WIDTH-1:0] model_out();
        return (sweep_left > 0) ? '0 : model_mem[address];
    endfunction

    task automatic check_state(input string tag);
        check({tag, " busy"}, 32'(busy), 32'(sweep_left > 0));
        check({tag, " out"}, 32'(out_d), 32'(model_out()));
    endtask

    task automatic cycle(input logic r, input logic l, input logic [AW-1:0] a,
                         input logic [WIDTH-1:0] d, input string tag);
        reset   = r;
        load    = l;
        address = a;
        in_d    = d;
        #1;
        check_state({tag, " pre"});
        @(posedge clk);
        model_edge();
        #1;
        check_state({tag, " post"});
    endtask

    task automatic read_at(input logic [AW-1:0] a, input string tag);
        reset   = 1'b0;
        load    = 1'b0;
        address = a;
        #1;
        check_state(tag);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks   = 0;
        n_pass     = 0;
        sweep_left = 0;
        foreach (model_mem[i]) model_mem[i] = 'x;

        // First reset: state is unknown beforehand, so only check after it.
        reset = 1'b1; load = 1'b0; address = '0; in_d = '0;
        @(posedge clk);
        model_edge();
        #1;
        check_state("reset1 post");
        check("reset1 busy const", 32'(busy), 32'd1);

        // Sweep of 8 edges; on edge 2 attempt a write that must be ignored.
        for (int e = 1; e <= DEPTH; e++) begin
            if (e == 2)
                cycle(1'b0, 1'b1, 3'd5, 16'hAAAA, "sweep1 ld5");
            else
                cycle(1'b0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)),
                      WIDTH'($urandom), "sweep1");
            check("sweep1 out zero", 32'(out_d), 32'(e < DEPTH ? 0 : out_d));
            check("sweep1 busy len", 32'(busy), 32'(e < DEPTH));
        end

        for (int a = 0; a < DEPTH; a++) begin
            read_at(AW'(a), "post-sweep read");
            check("post-sweep zero", 32'(out_d), 32'h0);
        end

        // Write 0xBEEF to address 3: old value before the edge, new after.
        reset = 1'b0; load = 1'b1; address = 3'd3; in_d = 16'hBEEF;
        #1;
        check("beef before", 32'(out_d), 32'h0000);
        @(posedge clk);
        model_edge();
        #1;
        check("beef after", 32'(out_d), 32'hBEEF);
        load = 1'b0;
        read_at(3'd4, "addr4 read");
        check("addr4 zero", 32'(out_d), 32'h0000);

        // load=0 across two edges leaves the word alone.
        cycle(1'b0, 1'b0, 3'd3, 16'h1234, "noload1");
        cycle(1'b0, 1'b0, 3'd3, 16'h1234, "noload2");
        check("noload hold", 32'(out_d), 32'hBEEF);

        // Boundary words.
        cycle(1'b0, 1'b1, 3'd7, 16'hFFFF, "wr7");
        cycle(1'b0, 1'b1, 3'd0, 16'h0001, "wr0");
        read_at(3'd7, "rd7");
        check("rd7 const", 32'(out_d), 32'hFFFF);
        read_at(3'd0, "rd0");
        check("rd0 const", 32'(out_d), 32'h0001);
        read_at(3'd6, "rd6");
        check("rd6 const", 32'(out_d), 32'h0000);

        // Random traffic while idle.
        for (int k = 0; k < 40; k++) begin
            cycle(1'b0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)),
                  WIDTH'($urandom), "rand");
        end

        // Reset, then reassert on sweep edge 4 together with a 0x5555 write.
        cycle(1'b1, 1'b0, 3'd2, 16'h0, "reset2");
        for (int e = 1; e <= 3; e++) begin
            cycle(1'b0, 1'b0, AW'($urandom_range(0, DEPTH - 1)), 16'h0, "sweep2");
        end
        cycle(1'b1, 1'b1, 3'd6, 16'h5555, "reset3 ld");
        check("reset3 busy const", 32'(busy), 32'd1);
        for (int e = 1; e <= DEPTH; e++) begin
            cycle(1'b0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)),
                  16'h5555, "sweep3");
            check("sweep3 busy len", 32'(busy), 32'(e < DEPTH));
        end
        for (int a = 0; a < DEPTH; a++) begin
            read_at(AW'(a), "final read");
            check("final zero", 32'(out_d), 32'h0000);
            check("no 5555", 32'(out_d == 16'h5555), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_ramn
